// File: rtl/ldpc_encoder.sv
// ldpc_encoder: serial systematic LDPC encoder, 18 info bits then 18 dual-diagonal parity bits per block.
module ldpc_encoder #(
  parameter int N_INFO    = 18,
  parameter int N_PAR     = 18,
  parameter int CNT_WIDTH = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic in_valid,
  input  logic in_bit,
  output logic in_ready,
  output logic out_valid,
  input  logic out_ready,
  output logic out_bit,
  output logic out_is_parity,
  output logic out_last,
  output logic busy
);
  typedef enum logic {LOAD, PARITY} state_t;
  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [N_PAR-1:0]     s_q, s_d;
  logic                 pacc_q, pacc_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_bit_q, out_bit_d;
  logic                 out_is_parity_q, out_is_parity_d;
  logic                 out_last_q, out_last_d;
  logic                 slot_free, xfer, par_go, par_bit;
  int                   i0, i5, i11;
  always_comb begin
    slot_free       = !out_valid_q || out_ready;
    in_ready        = en && !reset && state_q == LOAD && slot_free;
    xfer            = in_valid && in_ready;
    par_go          = en && state_q == PARITY && slot_free;
    i0              = int'(cnt_q);
    i5              = (i0 + 5) % N_PAR;
    i11             = (i0 + 11) % N_PAR;
    par_bit         = pacc_q ^ s_q[cnt_q];
    state_d         = state_q;
    cnt_d           = cnt_q;
    s_d             = s_q;
    pacc_d          = pacc_q;
    out_valid_d     = out_valid_q && !out_ready;
    out_bit_d       = out_bit_q;
    out_is_parity_d = out_is_parity_q;
    out_last_d      = out_last_q && !out_ready;
    if (xfer) begin
      for (int j = 0; j < N_PAR; j++)
        s_d[j] = s_q[j] ^ (in_bit && (j == i0 || j == i5 || j == i11));
      out_bit_d       = in_bit;
      out_valid_d     = 1'b1;
      out_is_parity_d = 1'b0;
      out_last_d      = 1'b0;
      state_d         = cnt_q == CNT_WIDTH'(N_INFO - 1) ? PARITY : LOAD;
      cnt_d           = cnt_q == CNT_WIDTH'(N_INFO - 1) ? '0 : cnt_q + CNT_WIDTH'(1);
      pacc_d          = cnt_q == CNT_WIDTH'(N_INFO - 1) ? 1'b0 : pacc_q;
    end else if (par_go) begin
      out_bit_d       = par_bit;
      pacc_d          = par_bit;
      out_valid_d     = 1'b1;
      out_is_parity_d = 1'b1;
      out_last_d      = cnt_q == CNT_WIDTH'(N_PAR - 1);
      state_d         = out_last_d ? LOAD : PARITY;
      cnt_d           = out_last_d ? '0 : cnt_q + CNT_WIDTH'(1);
      s_d             = out_last_d ? '0 : s_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= LOAD;
      cnt_q           <= '0;
      s_q             <= '0;
      pacc_q          <= 1'b0;
      out_valid_q     <= 1'b0;
      out_bit_q       <= 1'b0;
      out_is_parity_q <= 1'b0;
      out_last_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      s_q             <= s_d;
      pacc_q          <= pacc_d;
      out_valid_q     <= out_valid_d;
      out_bit_q       <= out_bit_d;
      out_is_parity_q <= out_is_parity_d;
      out_last_q      <= out_last_d;
    end
  end
  assign out_valid     = out_valid_q;
  assign out_bit       = out_bit_q;
  assign out_is_parity = out_is_parity_q;
  assign out_last      = out_last_q;
  assign busy          = !(state_q == LOAD && cnt_q == '0);
endmodule

// File: tb/tb_ldpc_encoder.sv
// tb_ldpc_encoder: directed and random-backpressure checks of ldpc_encoder against a codeword-level model.
module tb_ldpc_encoder;
  logic clk = 0, reset = 1, en = 1, in_valid = 0, in_bit = 0, out_ready = 1;
  logic in_ready, out_valid, out_bit, out_is_parity, out_last, busy;
  logic rmode = 0, b2b = 0;
  int checks = 0, errors = 0, cyc = 0, par_popped = 0;
  logic [2:0] exp_q[$];
  ldpc_encoder dut (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .out_is_parity(out_is_parity), .out_last(out_last), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1 out_ready = rmode ? ($urandom_range(0, 3) != 0) : 1'b1;
  end
  // Codeword from the parity-check definition: s_j over connected info bits, then p_j = p_(j-1) ^ s_j.
  function automatic logic [35:0] encode(input logic [17:0] u);
    logic [17:0] s;
    logic [35:0] cw;
    logic p;
    s = '0;
    for (int i = 0; i < 18; i++)
      if (u[i]) begin
        s[i] = ~s[i];
        s[(i + 5) % 18] = ~s[(i + 5) % 18];
        s[(i + 11) % 18] = ~s[(i + 11) % 18];
      end
    cw = '0;
    cw[17:0] = u;
    p = 1'b0;
    for (int j = 0; j < 18; j++) begin
      p = p ^ s[j];
      cw[18 + j] = p;
    end
    return cw;
  endfunction
  task automatic push_block(input logic [17:0] u);
    logic [35:0] cw;
    cw = encode(u);
    for (int k = 0; k < 36; k++) exp_q.push_back({cw[k], k >= 18, k == 35});
  endtask
  task automatic send_bit(input logic b);
    int t;
    in_valid = 1'b1;
    in_bit = b;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 300) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout got 0 want 1");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic send_block(input logic [17:0] u);
    for (int i = 0; i < 18; i++) send_bit(u[i]);
  endtask
  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk);
      #1 t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain remaining %0d want 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask
  // Output-side checker: model stream, hold stability, per-codeword check equations, b2b gaps.
  logic [35:0] cw_buf;
  int pos = 0, prev_cyc = 0;
  logic held = 0, prev_ok = 0;
  logic [2:0] hv, cur, e;
  always @(negedge clk) begin
    cur = {out_bit, out_is_parity, out_last};
    if (!b2b) prev_ok = 0;
    if (reset) begin
      pos = 0;
      held = 0;
    end else begin
      if (held) begin
        checks++;
        if (!out_valid || cur != hv) begin
          errors++;
          $display("FAIL hold got v%0b %b want v1 %b", out_valid, cur, hv);
        end
      end
      held = out_valid && !out_ready;
      hv = cur;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_bit got %b want none", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur != e) begin
            errors++;
            $display("FAIL stream pos %0d got %b want %b", pos, cur, e);
          end
        end
        if (b2b && prev_ok && cyc != prev_cyc + 1) begin
          errors++;
          $display("FAIL b2b_gap got %0d want 1", cyc - prev_cyc);
        end
        prev_ok = 1;
        prev_cyc = cyc;
        if (out_is_parity) par_popped++;
        if (pos < 36) cw_buf[pos] = out_bit;
        pos++;
        if (out_last) begin
          logic [17:0] bad;
          bad = '0;
          for (int j = 0; j < 18; j++) begin
            bad[j] = cw_buf[18 + j] ^ (j > 0 ? cw_buf[17 + j] : 1'b0);
            for (int i = 0; i < 18; i++)
              if (i == j || (i + 5) % 18 == j || (i + 11) % 18 == j) bad[j] = bad[j] ^ cw_buf[i];
          end
          checks++;
          if (bad != '0 || pos != 36) begin
            errors++;
            $display("FAIL checks syndrome %h len %0d want 0 len 36", bad, pos);
          end
          pos = 0;
        end
      end
    end
  end
  initial begin
    logic [35:0] lit;
    int base;
    logic [17:0] u;
    lit = 36'b1111111_000000_11111_00000000000000000_1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready || out_valid || busy || out_last) begin
      errors++;
      $display("FAIL reset_state got r%0b v%0b b%0b l%0b want 0000", in_ready, out_valid, busy, out_last);
    end
    @(posedge clk);
    #1 reset = 0;
    checks++;
    if (encode(18'h0) != 36'h0) begin
      errors++;
      $display("FAIL model_zero got %h want 0", encode(18'h0));
    end
    checks++;
    if (encode(18'h1) != lit) begin
      errors++;
      $display("FAIL model_u0 got %h want %h", encode(18'h1), lit);
    end
    push_block(18'h0);
    send_block(18'h0);
    drain();
    push_block(18'h1);
    send_block(18'h1);
    drain();
    b2b = 1;
    push_block(18'h3A5C1);
    push_block(18'h1F00F);
    send_block(18'h3A5C1);
    send_block(18'h1F00F);
    drain();
    b2b = 0;
    u = 18'h2D5A3;
    push_block(u);
    fork
      send_block(u);
      begin
        repeat (8) @(posedge clk);
        #1 en = 0;
        repeat (5) @(posedge clk);
        #1 en = 1;
      end
    join
    base = par_popped;
    for (int t = 0; t < 200 && par_popped < base + 3; t++) begin
      @(posedge clk);
      #1;
    end
    en = 0;
    repeat (5) @(posedge clk);
    #1 en = 1;
    drain();
    push_block(18'h15555);
    send_block(18'h15555);
    base = par_popped;
    for (int t = 0; t < 200 && par_popped < base + 7; t++) begin
      @(posedge clk);
      #1;
    end
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    exp_q.delete();
    checks++;
    if (out_valid || busy) begin
      errors++;
      $display("FAIL reset_mid got v%0b b%0b want v0 b0", out_valid, busy);
    end
    push_block(18'h1);
    send_block(18'h1);
    drain();
    rmode = 1;
    for (int n = 0; n < 1000; n++) begin
      u = 18'($urandom);
      push_block(u);
      send_block(u);
    end
    drain();
    rmode = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
